// File: rtl/mil_word_stream_encoder_if.sv
// Handshake bundle between a typed-word requester, the escape encoder and the push sink.
// The master modport is the environment side (requester plus sink); slave is the encoder.
interface mil_word_stream_encoder_if #(
  parameter int DATA_W = 16
);
  logic              in_request;
  logic [1:0]        in_type;
  logic [DATA_W-1:0] in_word;
  logic              in_done;
  logic              out_request;
  logic [DATA_W-1:0] out_data;
  logic              out_done;

  modport master (
    output in_request, in_type, in_word, out_done,
    input  in_done, out_request, out_data
  );

  modport slave (
    input  in_request, in_type, in_word, out_done,
    output in_done, out_request, out_data
  );
endinterface

// File: rtl/mil_word_stream_encoder.sv
// Buffers typed MIL words in a small FIFO and serialises each one onto a push stream,
// preceded by an escape word whenever the type or data pattern requires it.
module mil_word_stream_encoder #(
  parameter int                DATA_W     = 16,
  parameter int                DEPTH      = 4,
  parameter logic [DATA_W-1:0] ESC_BASE   = 16'hFFA0,
  parameter int                ALWAYS_ESC = 0,
  parameter int                CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mil_word_stream_encoder_if.slave bus,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]        esc_count
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ESC_LOAD,
    ESC_WAIT,
    DATA_LOAD,
    DATA_WAIT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W+1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              wr_en;
  logic              pop;
  logic              esc_inc;
  logic [1:0]        head_type;
  logic [DATA_W-1:0] head_word;
  logic              head_match;
  logic              need_esc;
  logic [DATA_W-1:0] esc_word;

  // The in_done term keeps a still-high request from being written twice.
  assign full      = (fifo_level == FULL_LEVEL);
  assign wr_en     = bus.in_request && !full && !bus.in_done;

  assign head_type  = mem[rd_ptr][DATA_W+1:DATA_W];
  assign head_word  = mem[rd_ptr][DATA_W-1:0];
  assign head_match = (head_word[DATA_W-1:2] == ESC_BASE[DATA_W-1:2]);
  assign need_esc   = (head_type != 2'd3) || head_match || (ALWAYS_ESC != 0);
  assign esc_word   = ESC_BASE | DATA_W'(head_type);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {bus.in_type, bus.in_word};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      bus.in_done <= 1'b0;
    end else begin
      bus.in_done <= wr_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The head entry stays put until DATA_WAIT completes, so both words come from one entry.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    esc_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          next_state = need_esc ? ESC_LOAD : DATA_LOAD;
        end
      end
      ESC_LOAD:  next_state = ESC_WAIT;
      ESC_WAIT: begin
        if (bus.out_done) begin
          esc_inc    = 1'b1;
          next_state = DATA_LOAD;
        end
      end
      DATA_LOAD: next_state = DATA_WAIT;
      DATA_WAIT: begin
        if (bus.out_done) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  // Registered push outputs: a LOAD state is always followed by a WAIT state,
  // so out_request can never be high two cycles running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_request <= 1'b0;
      bus.out_data    <= '0;
    end else begin
      bus.out_request <= (next_state == ESC_LOAD) || (next_state == DATA_LOAD);
      if (next_state == ESC_LOAD) begin
        bus.out_data <= esc_word;
      end else if (next_state == DATA_LOAD) begin
        bus.out_data <= head_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_count <= '0;
    end else if (esc_inc && (esc_count != '1)) begin
      esc_count <= esc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mil_word_stream_encoder.sv
// Scoreboard bench: two encoder configurations (default, and always-escape with a
// 2-bit counter and 2-deep FIFO) driven with directed and random typed words.
module tb_mil_word_stream_encoder;

  localparam logic [15:0] ESC_BASE = 16'hFFA0;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic [2:0]  level_a;
  logic [1:0]  level_b;
  logic [15:0] esc_a;
  logic [1:0]  esc_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int          esc_exp_a = 0;
  int          esc_exp_b = 0;
  bit          hold_a = 0, hold_b = 0;
  bit          rnd_a = 0, rnd_b = 0;
  bit          owed_a = 0, owed_b = 0;
  bit          prev_a = 0, prev_b = 0;

  mil_word_stream_encoder_if #(.DATA_W(16)) bus_a ();
  mil_word_stream_encoder_if #(.DATA_W(16)) bus_b ();

  mil_word_stream_encoder #(
    .DATA_W(16), .DEPTH(4), .ESC_BASE(16'hFFA0), .ALWAYS_ESC(0), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .fifo_level(level_a), .esc_count(esc_a)
  );

  mil_word_stream_encoder #(
    .DATA_W(16), .DEPTH(2), .ESC_BASE(16'hFFA0), .ALWAYS_ESC(1), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .fifo_level(level_b), .esc_count(esc_b)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each typed word becomes an optional escape word followed by the data.
  function automatic void model_word(input int which, input logic [1:0] t, input logic [15:0] w);
    bit esc;
    esc = (t != 2'd3) || ((w >> 2) == (ESC_BASE >> 2)) || (which == 1);
    if (which == 0) begin
      if (esc) begin
        exp_a.push_back(ESC_BASE + 16'(t));
        if (esc_exp_a < 65535) esc_exp_a++;
      end
      exp_a.push_back(w);
    end else begin
      if (esc) begin
        exp_b.push_back(ESC_BASE + 16'(t));
        if (esc_exp_b < 3) esc_exp_b++;
      end
      exp_b.push_back(w);
    end
  endfunction

  function automatic int qsize(input int which);
    return (which == 0) ? exp_a.size() : exp_b.size();
  endfunction

  function automatic logic [15:0] rand_word();
    if ($urandom_range(0, 3) == 0) return ESC_BASE | 16'($urandom_range(0, 3));
    return 16'($urandom);
  endfunction

  task automatic apply_stimulus(input int which, input logic [1:0] t, input logic [15:0] w,
                                input int lat);
    int    cyc;
    bit    got;
    string p;
    cyc = 0;
    got = 0;
    p   = (which == 0) ? "a_" : "b_";
    model_word(which, t, w);
    @(negedge clk);
    if (which == 0) begin
      bus_a.in_type = t; bus_a.in_word = w; bus_a.in_request = 1'b1;
    end else begin
      bus_b.in_type = t; bus_b.in_word = w; bus_b.in_request = 1'b1;
    end
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      got = (which == 0) ? bus_a.in_done : bus_b.in_done;
    end
    if (which == 0) bus_a.in_request = 1'b0;
    else            bus_b.in_request = 1'b0;
    if (!got) check_output({p, "in_done_timeout"}, 32'(got), 1);
    else if (lat > 0) check_output({p, "in_done_latency"}, cyc, lat);
  endtask

  task automatic drain(input int which);
    int    cyc;
    string p;
    cyc = 0;
    p   = (which == 0) ? "a_" : "b_";
    while (qsize(which) != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_output({p, "drain"}, qsize(which), 0);
    repeat (4) @(negedge clk);
    if (which == 0) begin
      check_output("a_level_empty", 32'(level_a), 0);
      check_output("a_esc_count", 32'(esc_a), esc_exp_a);
    end else begin
      check_output("b_level_empty", 32'(level_b), 0);
      check_output("b_esc_count", 32'(esc_b), esc_exp_b);
    end
  endtask

  // Push sinks: acknowledge one cycle after each out_request unless held back.
  initial begin
    bus_a.out_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rnd_a) hold_a = ($urandom_range(0, 3) == 0);
      if (rst_a) begin
        owed_a = 0;
        bus_a.out_done = 1'b0;
      end else begin
        if (bus_a.out_done) bus_a.out_done = 1'b0;
        else if (owed_a && !hold_a) begin
          bus_a.out_done = 1'b1;
          owed_a = 0;
        end
        if (bus_a.out_request) owed_a = 1;
      end
    end
  end

  initial begin
    bus_b.out_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rnd_b) hold_b = ($urandom_range(0, 3) == 0);
      if (rst_b) begin
        owed_b = 0;
        bus_b.out_done = 1'b0;
      end else begin
        if (bus_b.out_done) bus_b.out_done = 1'b0;
        else if (owed_b && !hold_b) begin
          bus_b.out_done = 1'b1;
          owed_b = 0;
        end
        if (bus_b.out_request) owed_b = 1;
      end
    end
  end

  // Monitor: every pushed word is compared with the head of its scoreboard queue.
  always @(negedge clk) begin
    if (!rst_a && bus_a.out_request) begin
      check_output("a_req_pulse", 32'(prev_a), 0);
      if (exp_a.size() == 0) check_output("a_extra_out", 32'(bus_a.out_request), 0);
      else check_output("a_out_data", 32'(bus_a.out_data), 32'(exp_a.pop_front()));
    end
    prev_a = !rst_a && bus_a.out_request;
    if (!rst_b && bus_b.out_request) begin
      check_output("b_req_pulse", 32'(prev_b), 0);
      if (exp_b.size() == 0) check_output("b_extra_out", 32'(bus_b.out_request), 0);
      else check_output("b_out_data", 32'(bus_b.out_data), 32'(exp_b.pop_front()));
    end
    prev_b = !rst_b && bus_b.out_request;
  end

  task automatic seq_a();
    int reqs;
    apply_stimulus(0, 2'd1, 16'h1234, 1);
    check_output("a_level_one", 32'(level_a), 1);
    drain(0);
    apply_stimulus(0, 2'd3, 16'h00FF, 1);
    drain(0);
    apply_stimulus(0, 2'd3, 16'hFFA2, 1);
    drain(0);

    hold_a = 1;
    for (int i = 1; i <= 4; i++) apply_stimulus(0, 2'd3, 16'(i), 1);
    check_output("a_level_full", 32'(level_a), 4);
    fork
      apply_stimulus(0, 2'd3, 16'h0005, 0);
      begin
        int seen = 0;
        repeat (6) begin
          @(negedge clk);
          if (bus_a.in_done) seen++;
        end
        check_output("a_full_stall", seen, 0);
        check_output("a_level_held", 32'(level_a), 4);
        hold_a = 0;
      end
    join
    drain(0);

    rnd_a = 1;
    for (int i = 0; i < 40; i++) apply_stimulus(0, 2'($urandom_range(0, 3)), rand_word(), 0);
    rnd_a = 0;
    hold_a = 0;
    drain(0);

    // Reset while the first of three queued words sits in ESC_WAIT.
    hold_a = 1;
    apply_stimulus(0, 2'd1, 16'h0AAA, 1);
    apply_stimulus(0, 2'd3, 16'h0101, 1);
    apply_stimulus(0, 2'd3, 16'h0202, 1);
    repeat (3) @(negedge clk);
    check_output("a_level_before_rst", 32'(level_a), 3);
    rst_a = 1'b1;
    #1;
    check_output("a_rst_out_request", 32'(bus_a.out_request), 0);
    check_output("a_rst_out_data", 32'(bus_a.out_data), 0);
    check_output("a_rst_level", 32'(level_a), 0);
    check_output("a_rst_esc_count", 32'(esc_a), 0);
    exp_a.delete();
    esc_exp_a = 0;
    hold_a = 0;
    owed_a = 0;
    bus_a.out_done = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.out_request) reqs++;
    end
    check_output("a_quiet_after_rst", reqs, 0);
    apply_stimulus(0, 2'd3, 16'h5A5A, 1);
    drain(0);
  endtask

  task automatic seq_b();
    apply_stimulus(1, 2'd3, 16'h0042, 1);
    drain(1);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 2'd0, rand_word(), 0);
    drain(1);
    check_output("b_esc_saturated", 32'(esc_b), 3);
    rnd_b = 1;
    for (int i = 0; i < 20; i++) apply_stimulus(1, 2'($urandom_range(0, 3)), rand_word(), 0);
    rnd_b = 0;
    hold_b = 0;
    drain(1);
  endtask

  initial begin
    bus_a.in_request = 1'b0; bus_a.in_type = 2'd0; bus_a.in_word = 16'h0;
    bus_b.in_request = 1'b0; bus_b.in_type = 2'd0; bus_b.in_word = 16'h0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check_output("a_reset_level", 32'(level_a), 0);
    check_output("a_reset_esc", 32'(esc_a), 0);
    check_output("a_reset_req", 32'(bus_a.out_request), 0);
    check_output("a_reset_data", 32'(bus_a.out_data), 0);
    check_output("a_reset_in_done", 32'(bus_a.in_done), 0);
    check_output("b_reset_level", 32'(level_b), 0);
    check_output("b_reset_esc", 32'(esc_b), 0);
    check_output("b_reset_req", 32'(bus_b.out_request), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      seq_a();
      seq_b();
    join
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/mil_word_stream_encoder.md
Name: mil_word_stream_encoder

Overview:
- Parametrised successor to the single-word MIL-to-memory escape encoder.
- Accepts typed MIL words (type + data) through a request/done handshake and buffers them in an internal FIFO of DEPTH entries.
- Serialises each entry onto a push stream: an optional escape word, then the data word.
- Adds configurable data width, escape base, an always-tag mode, FIFO decoupling and a saturating escape statistics counter.

Parameters:
- DATA_W, 16: width of MIL data word and push data.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- ESC_BASE, 16'hFFA0: escape base; bits [1:0] must be 0. Width is DATA_W.
- ALWAYS_ESC, 0: 1 = emit escape word before every word, including plain WDATA.
- CNT_W, 16: width of esc_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_request  in  1  level; typed word valid; held until in_done.
- in_type  in  2  0=WSERVERR, 1=WSERV, 2=WDATAERR, 3=WDATA.
- in_word  in  DATA_W  MIL data word.
- in_done  out  1  one-cycle pulse; word accepted into FIFO.
- out_request  out  1  one-cycle pulse; out_data valid.
- out_data  out  DATA_W  push data word.
- out_done  in  1  one-cycle pulse from push sink; word consumed.
- fifo_level  out  $clog2(DEPTH)+1  occupied entries.
- esc_count  out  CNT_W  escape words emitted, saturating.

Behaviour:
- Reset (async, any state): FSM to IDLE; FIFO pointers and level to 0; in_done=0, out_request=0, out_data=0, esc_count=0. An in-flight word is discarded; the sink must ignore a pending out_done after reset.
- Escape detection: match = (word[DATA_W-1:2] == ESC_BASE[DATA_W-1:2]).
- Escape word = ESC_BASE | type, i.e. FFA0/FFA1/FFA2/FFA3 at defaults.
- Escape is needed when type != WDATA, or when match=1, or when ALWAYS_ESC=1.
- Input side:
  - Write occurs on a cycle with in_request=1, FIFO not full, and in_done=0 that cycle (blocks double-accept).
  - in_done pulses on the next cycle; latency 1.
  - While full, in_request is stalled (no in_done); the word must stay stable.
  - Requester deasserts in_request in the cycle after in_done.
- FIFO:
  - Entry = {type, word}, DATA_W+2 bits.
  - Pointers wrap modulo DEPTH.
  - Simultaneous write and pop: level unchanged; data stays correct when level=1.
  - Pop only from a non-empty FIFO.
- Output FSM, states IDLE, ESC_LOAD, ESC_WAIT, DATA_LOAD, DATA_WAIT:
  - IDLE: if level>0, go to ESC_LOAD if the head needs an escape, else DATA_LOAD.
  - ESC_LOAD: out_request=1, out_data=escape word; go to ESC_WAIT.
  - ESC_WAIT: out_data held; on out_done, increment esc_count (saturate at all-ones) and go to DATA_LOAD.
  - DATA_LOAD: out_request=1, out_data=head word; go to DATA_WAIT.
  - DATA_WAIT: out_data held; on out_done, pop the head and go to IDLE.
  - out_done outside the WAIT states is ignored.
  - out_request is registered from the state and is never high for two consecutive cycles.
  - out_data keeps its last value in IDLE.
- Throughput: minimum 3 cycles per unescaped word (IDLE, LOAD, WAIT with immediate out_done); 5 per escaped word.
- in_done and out_done in the same cycle are independent.

Test Plan:
- Reset, then WSERV word 16'h1234 with out_done returned one cycle after each out_request -> in_done one cycle after request; out_data sequence FFA1, 1234; esc_count=1; fifo_level 1 then 0.
- WDATA 16'h00FF -> single out_request, out_data=00FF, esc_count unchanged. Then WDATA 16'hFFA2 -> out_data FFA3, FFA2.
- DEPTH=4, out_done withheld, push 5 WDATA words (0001..0005) -> 4 in_done pulses, fifo_level=4, 5th stalled. Release sink -> 5th accepted after first pop; output order 0001..0005 exactly.
- ALWAYS_ESC=1, WDATA 16'h0042 -> FFA3, 0042; esc_count increments.
- Assert rst while in ESC_WAIT with 2 words queued -> outputs 0 immediately; fifo_level=0; no out_request afterwards until a new in_request.
- CNT_W=2, send 5 WSERVERR words -> esc_count saturates at 3.
